// File: rtl/rfsoc_load_sequencer.sv
// rfsoc_load_sequencer: header-driven waveform loader feeding the DAC driver lanes.
// A header beat picks a channel and a beat count, and the next N beats pass
// straight through to that lane. An END header finishes the session.
module rfsoc_load_sequencer #(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 256,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                               pl_clk,
    input  logic                               rst,
    input  logic                               seq_en,
    input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0] m_axis_tdata,
    output logic [NUM_CHANNELS-1:0]            m_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]            m_axis_tready,
    output logic [NUM_CHANNELS-1:0]            channel_select,
    output logic                               busy,
    output logic                               done,
    output logic                               err_bad_hdr,
    output logic                               err_abort,
    output logic [31:0]                        beat_total
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_END  = 8'h02;

    logic [1:0]           r_state;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [CH_W-1:0]      r_ch;
    logic                 r_err_bad_hdr;
    logic                 r_err_abort;
    logic [31:0]          r_beat_total;

    logic [7:0]             w_opcode;
    logic [3:0]             w_hdr_ch;
    logic [LEN_WIDTH-1:0]   w_hdr_len;
    logic                   w_hdr_ok;
    logic                   w_hs;
    logic                   w_s_ready;
    logic [NUM_CHANNELS-1:0] w_m_valid;
    logic [NUM_CHANNELS-1:0] w_sel;

    // Header field decode; only meaningful while in HDR.
    assign w_opcode  = s_axis_tdata[DATA_WIDTH-1 -: 8];
    assign w_hdr_ch  = s_axis_tdata[3:0];
    assign w_hdr_len = s_axis_tdata[16 +: LEN_WIDTH];
    assign w_hdr_ok  = (w_opcode == OP_LOAD) && (32'(w_hdr_ch) < NUM_CHANNELS) &&
                       (w_hdr_len != '0);

    assign w_hs = s_axis_tvalid && w_s_ready;

    // Upstream ready: always open for headers, follows the selected lane in DATA.
    // Dropping seq_en in DATA closes it in the same cycle so no beat is lost.
    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            S_HDR:   w_s_ready = 1'b1;
            S_DATA:  w_s_ready = seq_en && m_axis_tready[r_ch];
            default: w_s_ready = 1'b0;
        endcase
    end

    // Zero-latency valid steering to the registered channel only.
    always_comb begin
        w_m_valid = '0;
        if (r_state == S_DATA && seq_en)
            w_m_valid[r_ch] = s_axis_tvalid;
    end

    // One-hot channel indicator, decoded from registered state so it clears
    // together with the state (including on async reset).
    always_comb begin
        w_sel = '0;
        if (r_state == S_DATA)
            w_sel[r_ch] = 1'b1;
    end

    // Main sequencer: state, beat counter, channel latch, sticky errors, totals.
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ch          <= '0;
            r_err_bad_hdr <= 1'b0;
            r_err_abort   <= 1'b0;
            r_beat_total  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (seq_en) begin
                        r_state       <= S_HDR;
                        r_err_bad_hdr <= 1'b0;
                        r_err_abort   <= 1'b0;
                        r_beat_total  <= '0;
                    end
                end
                S_HDR: begin
                    if (!seq_en) begin
                        r_state <= S_IDLE;
                    end else if (w_hs) begin
                        if (w_hdr_ok) begin
                            r_cnt   <= w_hdr_len;
                            r_ch    <= w_hdr_ch[CH_W-1:0];
                            r_state <= S_DATA;
                        end else if (w_opcode == OP_END) begin
                            r_state <= S_DONE;
                        end else begin
                            r_err_bad_hdr <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (!seq_en) begin
                        r_err_abort <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_hs) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_beat_total != 32'hFFFF_FFFF)
                            r_beat_total <= r_beat_total + 32'd1;
                        if (r_cnt == LEN_WIDTH'(1))
                            r_state <= S_HDR;
                    end
                end
                S_DONE: begin
                    if (!seq_en)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_axis_tready  = w_s_ready;
    assign m_axis_tdata   = {NUM_CHANNELS{s_axis_tdata}};
    assign m_axis_tvalid  = w_m_valid;
    assign channel_select = w_sel;
    assign busy           = (r_state == S_HDR) || (r_state == S_DATA);
    assign done           = (r_state == S_DONE);
    assign err_bad_hdr    = r_err_bad_hdr;
    assign err_abort      = r_err_abort;
    assign beat_total     = r_beat_total;

endmodule

// File: tb/tb_rfsoc_load_sequencer.sv
// Directed bench for rfsoc_load_sequencer. A second, 8-channel instance shares
// the upstream stimulus so an out-of-range channel index can be exercised.
module tb_rfsoc_load_sequencer;

    localparam int DW = 256;

    logic pl_clk, rst, seq_en;
    logic [DW-1:0] s_axis_tdata;
    logic s_axis_tvalid;

    logic          s_rdy16;
    logic [DW*16-1:0] m_data16;
    logic [15:0]   m_vld16, m_rdy16, sel16;
    logic          busy16, done16, ebad16, eab16;
    logic [31:0]   tot16;

    logic          s_rdy8;
    logic [DW*8-1:0] m_data8;
    logic [7:0]    m_vld8, m_rdy8, sel8;
    logic          busy8, done8, ebad8, eab8;
    logic [31:0]   tot8;

    int vecs = 0;
    int errs = 0;

    rfsoc_load_sequencer #(.NUM_CHANNELS(16), .DATA_WIDTH(DW), .LEN_WIDTH(16)) dut (
        .pl_clk(pl_clk), .rst(rst), .seq_en(seq_en),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_rdy16),
        .m_axis_tdata(m_data16), .m_axis_tvalid(m_vld16), .m_axis_tready(m_rdy16),
        .channel_select(sel16), .busy(busy16), .done(done16),
        .err_bad_hdr(ebad16), .err_abort(eab16), .beat_total(tot16)
    );

    rfsoc_load_sequencer #(.NUM_CHANNELS(8), .DATA_WIDTH(DW), .LEN_WIDTH(16)) dut8 (
        .pl_clk(pl_clk), .rst(rst), .seq_en(seq_en),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_rdy8),
        .m_axis_tdata(m_data8), .m_axis_tvalid(m_vld8), .m_axis_tready(m_rdy8),
        .channel_select(sel8), .busy(busy8), .done(done8),
        .err_bad_hdr(ebad8), .err_abort(eab8), .beat_total(tot8)
    );

    initial pl_clk = 1'b0;
    always #5 pl_clk = ~pl_clk;

    function automatic logic [DW-1:0] hdr(input logic [7:0] op, input logic [3:0] ch,
                                          input logic [15:0] n);
        logic [DW-1:0] h;
        h = '0;
        h[255:248] = op;
        h[3:0]     = ch;
        h[31:16]   = n;
        return h;
    endfunction

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge pl_clk);
        vecs++;
        if ({s_rdy16, m_vld16, sel16, busy16, done16, ebad16, eab16} !== '0) begin
            errs++;
            $display("FAIL reset_ctl: got rdy=%b vld=%h sel=%h busy=%b done=%b eb=%b ea=%b, expected all 0",
                     s_rdy16, m_vld16, sel16, busy16, done16, ebad16, eab16);
        end
        vecs++;
        if (tot16 !== 32'd0) begin
            errs++; $display("FAIL reset_total: got %0d expected 0", tot16);
        end
    endtask

    task automatic test_load_basic();
        logic [DW-1:0] d;
        seq_en = 1'b1;
        tick();
        s_axis_tdata = hdr(8'h01, 4'd3, 16'd4); s_axis_tvalid = 1'b1;
        @(negedge pl_clk);
        vecs++;
        if (s_rdy16 !== 1'b1 || busy16 !== 1'b1) begin
            errs++; $display("FAIL hdr_ready: got rdy=%b busy=%b expected 1 1", s_rdy16, busy16);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            d = '0; d[15:0] = 16'(100 + i); d[255:248] = 8'hA5;
            s_axis_tdata = d;
            @(negedge pl_clk);
            vecs++;
            if (m_vld16 !== 16'h0008 || sel16 !== 16'h0008 || s_rdy16 !== 1'b1) begin
                errs++;
                $display("FAIL load_beat%0d: got vld=%h sel=%h rdy=%b expected 0008 0008 1",
                         i, m_vld16, sel16, s_rdy16);
            end
            vecs++;
            if (m_data16[3*DW +: DW] !== d) begin
                errs++; $display("FAIL load_data%0d: got %h expected %h", i, m_data16[3*DW +: 16], d[15:0]);
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (sel16 !== 16'h0 || s_rdy16 !== 1'b1 || tot16 !== 32'd4 || busy16 !== 1'b1) begin
            errs++;
            $display("FAIL load_after: got sel=%h rdy=%b total=%0d busy=%b expected 0 1 4 1",
                     sel16, s_rdy16, tot16, busy16);
        end
    endtask

    task automatic test_end();
        s_axis_tdata = hdr(8'h01, 4'd15, 16'd2); s_axis_tvalid = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = DW'(200 + i);
            @(negedge pl_clk);
            vecs++;
            if (m_vld16 !== 16'h8000) begin
                errs++; $display("FAIL end_lane15_%0d: got vld=%h expected 8000", i, m_vld16);
            end
            tick();
        end
        s_axis_tdata = hdr(8'h02, 4'd0, 16'd0);
        tick();
        s_axis_tvalid = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (done16 !== 1'b1 || busy16 !== 1'b0 || s_rdy16 !== 1'b0 || tot16 !== 32'd6) begin
            errs++;
            $display("FAIL end_done: got done=%b busy=%b rdy=%b total=%0d expected 1 0 0 6",
                     done16, busy16, s_rdy16, tot16);
        end
        tick();
        @(negedge pl_clk);
        vecs++;
        if (done16 !== 1'b1) begin
            errs++; $display("FAIL end_hold: got done=%b expected 1", done16);
        end
        tick();
        seq_en = 1'b0;
        tick();
        @(negedge pl_clk);
        vecs++;
        if (done16 !== 1'b0 || busy16 !== 1'b0 || s_rdy16 !== 1'b0) begin
            errs++; $display("FAIL end_idle: got done=%b busy=%b rdy=%b expected 0 0 0",
                             done16, busy16, s_rdy16);
        end
    endtask

    task automatic test_backpressure();
        logic pat [5];
        int hs;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        hs = 0;
        seq_en = 1'b1;
        tick();
        s_axis_tdata = hdr(8'h01, 4'd0, 16'd3); s_axis_tvalid = 1'b1;
        tick();
        s_axis_tdata = DW'(16'h0BEE);
        for (int i = 0; i < 5; i++) begin
            m_rdy16[0] = pat[i];
            @(negedge pl_clk);
            vecs++;
            if (s_rdy16 !== pat[i] || m_vld16 !== 16'h0001) begin
                errs++; $display("FAIL bp_cycle%0d: got rdy=%b vld=%h expected %b 0001",
                                 i, s_rdy16, m_vld16, pat[i]);
            end
            if (s_rdy16 === 1'b1) hs++;
            tick();
        end
        s_axis_tvalid = 1'b0; m_rdy16[0] = 1'b1;
        @(negedge pl_clk);
        vecs++;
        if (hs != 3 || tot16 !== 32'd3 || sel16 !== 16'h0 || s_rdy16 !== 1'b1) begin
            errs++; $display("FAIL bp_after: got hs=%0d total=%0d sel=%h rdy=%b expected 3 3 0 1",
                             hs, tot16, sel16, s_rdy16);
        end
    endtask

    task automatic test_bad_hdr();
        s_axis_tdata = hdr(8'h07, 4'd1, 16'd1); s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (ebad16 !== 1'b1 || busy16 !== 1'b1 || sel16 !== 16'h0 || s_rdy16 !== 1'b1) begin
            errs++; $display("FAIL bad_opcode: got err=%b busy=%b sel=%h rdy=%b expected 1 1 0 1",
                             ebad16, busy16, sel16, s_rdy16);
        end
        tick();
        s_axis_tdata = hdr(8'h01, 4'd2, 16'd0); s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (ebad16 !== 1'b1 || sel16 !== 16'h0 || s_rdy16 !== 1'b1) begin
            errs++; $display("FAIL bad_len0: got err=%b sel=%h rdy=%b expected 1 0 1", ebad16, sel16, s_rdy16);
        end
        tick();
        s_axis_tdata = hdr(8'h01, 4'd2, 16'd1); s_axis_tvalid = 1'b1;
        tick();
        s_axis_tdata = DW'(16'h1234);
        @(negedge pl_clk);
        vecs++;
        if (sel16 !== 16'h0004 || m_vld16 !== 16'h0004 || ebad16 !== 1'b1) begin
            errs++; $display("FAIL bad_recover: got sel=%h vld=%h err=%b expected 0004 0004 1",
                             sel16, m_vld16, ebad16);
        end
        tick();
        s_axis_tvalid = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (sel16 !== 16'h0 || s_rdy16 !== 1'b1 || tot16 !== 32'd4) begin
            errs++; $display("FAIL bad_recover_end: got sel=%h rdy=%b total=%0d expected 0 1 4",
                             sel16, s_rdy16, tot16);
        end
        // Out-of-range channel on the 8-lane instance, fresh session.
        seq_en = 1'b0; tick();
        seq_en = 1'b1; tick();
        @(negedge pl_clk);
        vecs++;
        if (ebad16 !== 1'b0 || ebad8 !== 1'b0) begin
            errs++; $display("FAIL bad_clear: got err16=%b err8=%b expected 0 0", ebad16, ebad8);
        end
        s_axis_tdata = hdr(8'h01, 4'd15, 16'd1); s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (sel16 !== 16'h8000 || ebad16 !== 1'b0) begin
            errs++; $display("FAIL ch15_16lane: got sel=%h err=%b expected 8000 0", sel16, ebad16);
        end
        vecs++;
        if (ebad8 !== 1'b1 || sel8 !== 8'h0 || busy8 !== 1'b1 || s_rdy8 !== 1'b1) begin
            errs++; $display("FAIL ch15_8lane: got err=%b sel=%h busy=%b rdy=%b expected 1 0 1 1",
                             ebad8, sel8, busy8, s_rdy8);
        end
        s_axis_tdata = '0; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_abort();
        seq_en = 1'b0; tick();
        seq_en = 1'b1; tick();
        s_axis_tdata = hdr(8'h01, 4'd5, 16'd10); s_axis_tvalid = 1'b1;
        tick();
        s_axis_tdata = DW'(16'h5555);
        for (int i = 0; i < 4; i++) tick();
        seq_en = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (s_rdy16 !== 1'b0 || m_vld16 !== 16'h0 || sel16 !== 16'h0020) begin
            errs++; $display("FAIL abort_gate: got rdy=%b vld=%h sel=%h expected 0 0 0020",
                             s_rdy16, m_vld16, sel16);
        end
        tick();
        s_axis_tvalid = 1'b0;
        @(negedge pl_clk);
        vecs++;
        if (eab16 !== 1'b1 || tot16 !== 32'd4 || sel16 !== 16'h0 || busy16 !== 1'b0) begin
            errs++; $display("FAIL abort_state: got ea=%b total=%0d sel=%h busy=%b expected 1 4 0 0",
                             eab16, tot16, sel16, busy16);
        end
        seq_en = 1'b1;
        tick();
        @(negedge pl_clk);
        vecs++;
        if (eab16 !== 1'b0 || tot16 !== 32'd0 || busy16 !== 1'b1) begin
            errs++; $display("FAIL abort_clear: got ea=%b total=%0d busy=%b expected 0 0 1",
                             eab16, tot16, busy16);
        end
    endtask

    task automatic test_async_reset();
        s_axis_tdata = hdr(8'h01, 4'd6, 16'd5); s_axis_tvalid = 1'b1;
        tick();
        s_axis_tdata = DW'(16'h6666);
        tick();
        @(negedge pl_clk);
        vecs++;
        if (sel16 !== 16'h0040 || m_vld16 !== 16'h0040 || tot16 !== 32'd1) begin
            errs++; $display("FAIL ar_pre: got sel=%h vld=%h total=%0d expected 0040 0040 1",
                             sel16, m_vld16, tot16);
        end
        #2 rst = 1'b0;
        #1;
        vecs++;
        if ({s_rdy16, m_vld16, sel16, busy16, done16, ebad16, eab16} !== '0 || tot16 !== 32'd0) begin
            errs++;
            $display("FAIL ar_immediate: got rdy=%b vld=%h sel=%h busy=%b total=%0d expected all 0",
                     s_rdy16, m_vld16, sel16, busy16, tot16);
        end
        tick();
        s_axis_tvalid = 1'b0; seq_en = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; seq_en = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        m_rdy16 = '1; m_rdy8 = '1;
        tick(); tick();
        test_reset();
        tick();
        rst = 1'b1;
        tick();
        test_load_basic();
        tick();
        test_end();
        tick();
        test_backpressure();
        tick();
        test_bad_hdr();
        test_abort();
        tick();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
